// File: rtl/lc3_controller.sv
// lc3_controller
//   Central sequencing FSM for the LC-3 core. Each instruction moves through
//   fetch, decode, execute, optional memory access, writeback and PC update.
//
//   Ports:
//     clk, reset           core clock; synchronous active-high reset
//     complete_instr       instruction memory returned instr_dout
//     complete_data        data memory access finished
//     instr_dout[15:0]     instruction word from memory
//     psr[2:0]             condition codes {N,Z,P}
//     state                current controller state (shared enum)
//     enable_*             per-stage enables (one-hot with the stage states)
//     mem_state[1:0]       0=read, 1=write, 2=indirect-address read, 3=idle
//     branch_taken         registered PC-redirect decision for fetch

package lc3_pkg;
    typedef enum logic [2:0] {
        CNTRL_FETCH       = 3'd0,
        CNTRL_DECODE      = 3'd1,
        CNTRL_EXECUTE     = 3'd2,
        CNTRL_WRITEBACK   = 3'd3,
        CNTRL_UPDATE_PC   = 3'd4,
        CNTRL_READ_MEM    = 3'd5,
        CNTRL_WRITE_MEM   = 3'd6,
        CNTRL_IND_ADDR_RD = 3'd7
    } cntrl_state_t;
endpackage

module lc3_controller
    import lc3_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         complete_instr,
    input  logic         complete_data,
    input  logic [15:0]  instr_dout,
    input  logic [2:0]   psr,
    output cntrl_state_t state,
    output logic         enable_fetch,
    output logic         enable_decode,
    output logic         enable_execute,
    output logic         enable_writeback,
    output logic         enable_update_pc,
    output logic [1:0]   mem_state,
    output logic         branch_taken
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [15:0]  ir;
    logic [3:0]   opcode;
    cntrl_state_t next_state;
    logic         branch_next;

    // Operand fields below the BR condition bits are consumed by the
    // datapath stages, not by the sequencer.
    logic         ir_operand_unused;

    assign opcode            = ir[15:12];
    assign ir_operand_unused = ^ir[8:0];

    // Next-state and branch decision
    always_comb begin
        next_state  = state;
        branch_next = 1'b0;

        case (opcode)
            OP_BR:   branch_next = |(ir[11:9] & psr);
            OP_JMP:  branch_next = 1'b1;
            default: branch_next = 1'b0;
        endcase

        case (state)
            CNTRL_FETCH: begin
                if (complete_instr)
                    next_state = CNTRL_DECODE;
            end
            CNTRL_DECODE: next_state = CNTRL_EXECUTE;
            CNTRL_EXECUTE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: next_state = CNTRL_WRITEBACK;
                    OP_LD, OP_LDR:                  next_state = CNTRL_READ_MEM;
                    OP_LDI, OP_STI:                 next_state = CNTRL_IND_ADDR_RD;
                    OP_ST, OP_STR:                  next_state = CNTRL_WRITE_MEM;
                    // BR, JMP, and RTI/TRAP/reserved (treated as NOP)
                    default:                        next_state = CNTRL_UPDATE_PC;
                endcase
            end
            CNTRL_READ_MEM: begin
                if (complete_data)
                    next_state = CNTRL_WRITEBACK;
            end
            CNTRL_IND_ADDR_RD: begin
                if (complete_data)
                    next_state = (opcode == OP_STI) ? CNTRL_WRITE_MEM : CNTRL_READ_MEM;
            end
            CNTRL_WRITE_MEM: begin
                if (complete_data)
                    next_state = CNTRL_UPDATE_PC;
            end
            CNTRL_WRITEBACK: next_state = CNTRL_UPDATE_PC;
            CNTRL_UPDATE_PC: next_state = CNTRL_FETCH;
            default:         next_state = CNTRL_FETCH;
        endcase
    end

    // Moore outputs
    always_comb begin
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        enable_update_pc = 1'b0;
        mem_state        = 2'd3;

        case (state)
            CNTRL_FETCH:       enable_fetch     = 1'b1;
            CNTRL_DECODE:      enable_decode    = 1'b1;
            CNTRL_EXECUTE:     enable_execute   = 1'b1;
            CNTRL_WRITEBACK:   enable_writeback = 1'b1;
            CNTRL_UPDATE_PC:   enable_update_pc = 1'b1;
            CNTRL_READ_MEM:    mem_state        = 2'd0;
            CNTRL_WRITE_MEM:   mem_state        = 2'd1;
            CNTRL_IND_ADDR_RD: mem_state        = 2'd2;
            default:           mem_state        = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CNTRL_FETCH;
            ir           <= '0;
            branch_taken <= 1'b0;
        end else begin
            state <= next_state;

            if (state == CNTRL_FETCH && complete_instr)
                ir <= instr_dout;

            // psr is only looked at on EXECUTE exit; the decision then holds
            // through UPDATE_PC and is dropped as the next fetch begins.
            if (state == CNTRL_EXECUTE)
                branch_taken <= branch_next;
            else if (next_state == CNTRL_FETCH)
                branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_controller.sv
module tb_lc3_controller;
    import lc3_pkg::*;

    logic         clk;
    logic         reset;
    logic         complete_instr;
    logic         complete_data;
    logic [15:0]  instr_dout;
    logic [2:0]   psr;
    cntrl_state_t dut_state;
    logic         enable_fetch;
    logic         enable_decode;
    logic         enable_execute;
    logic         enable_writeback;
    logic         enable_update_pc;
    logic [1:0]   mem_state;
    logic         branch_taken;

    lc3_controller dut (
        .clk              (clk),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .instr_dout       (instr_dout),
        .psr              (psr),
        .state            (dut_state),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_update_pc (enable_update_pc),
        .mem_state        (mem_state),
        .branch_taken     (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus what the outputs must be during that cycle
    typedef struct {
        logic         rst;
        logic         ci;
        logic         cd;
        logic [2:0]   psr_v;
        logic [15:0]  instr_v;
        cntrl_state_t st;
        logic         bt;
    } item_t;

    // Instruction test vectors
    typedef struct {
        logic [15:0] instr;
        logic [2:0]  psr_e;
        int unsigned fetch_stall;
        int unsigned data_stall;
    } vec_t;

    localparam logic [15:0] JUNK = 16'hC000;

    item_t stim_q[$];
    item_t exp_q[$];
    int    n_checks;
    int    n_pass;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [1:0] exp_mem(input cntrl_state_t s);
        case (s)
            CNTRL_READ_MEM:    return 2'd0;
            CNTRL_WRITE_MEM:   return 2'd1;
            CNTRL_IND_ADDR_RD: return 2'd2;
            default:           return 2'd3;
        endcase
    endfunction

    task automatic push(input logic rst, input logic ci, input logic cd, input logic [2:0] p,
                        input logic [15:0] ins, input cntrl_state_t st, input logic bt);
        item_t it;
        it.rst = rst; it.ci = ci; it.cd = cd; it.psr_v = p;
        it.instr_v = ins; it.st = st; it.bt = bt;
        stim_q.push_back(it);
    endtask

    task automatic push_wait(input cntrl_state_t st, input int unsigned stall,
                             input logic [2:0] p, input logic bt);
        for (int unsigned i = 0; i < stall; i++)
            push(1'b0, 1'b1, 1'b0, p, JUNK, st, bt);
        push(1'b0, 1'b1, 1'b1, p, JUNK, st, bt);
    endtask

    // Expected cycle-by-cycle path of one instruction
    task automatic build_instr(input vec_t v);
        logic [3:0]  op;
        logic [2:0]  cc;
        logic [2:0]  p_other;
        logic        b;
        op      = v.instr[15:12];
        cc      = v.instr[11:9];
        p_other = ~v.psr_e;
        if (op == 4'b0000)      b = |(cc & v.psr_e);
        else if (op == 4'b1100) b = 1'b1;
        else                    b = 1'b0;

        for (int unsigned i = 0; i < v.fetch_stall; i++)
            push(1'b0, 1'b0, 1'b1, p_other, JUNK, CNTRL_FETCH, 1'b0);
        push(1'b0, 1'b1, 1'b1, p_other, v.instr, CNTRL_FETCH,   1'b0);
        push(1'b0, 1'b1, 1'b1, p_other, JUNK,    CNTRL_DECODE,  1'b0);
        push(1'b0, 1'b1, 1'b1, v.psr_e, JUNK,    CNTRL_EXECUTE, 1'b0);

        case (op)
            4'b0001, 4'b0101, 4'b1001, 4'b1110: begin
                push(1'b0, 1'b1, 1'b1, p_other, JUNK, CNTRL_WRITEBACK, b);
            end
            4'b0010, 4'b0110: begin
                push_wait(CNTRL_READ_MEM, v.data_stall, p_other, b);
                push(1'b0, 1'b1, 1'b1, p_other, JUNK, CNTRL_WRITEBACK, b);
            end
            4'b1010: begin
                push_wait(CNTRL_IND_ADDR_RD, v.data_stall, p_other, b);
                push_wait(CNTRL_READ_MEM, v.data_stall, p_other, b);
                push(1'b0, 1'b1, 1'b1, p_other, JUNK, CNTRL_WRITEBACK, b);
            end
            4'b1011: begin
                push_wait(CNTRL_IND_ADDR_RD, v.data_stall, p_other, b);
                push_wait(CNTRL_WRITE_MEM, v.data_stall, p_other, b);
            end
            4'b0011, 4'b0111: begin
                push_wait(CNTRL_WRITE_MEM, v.data_stall, p_other, b);
            end
            default: ;
        endcase
        push(1'b0, 1'b1, 1'b1, p_other, JUNK, CNTRL_UPDATE_PC, b);
    endtask

    // Called at posedge+1: drive, record expectation, compare at negedge
    task automatic run_queue();
        item_t it;
        item_t e;
        while (stim_q.size() > 0) begin
            it = stim_q.pop_front();
            reset          = it.rst;
            complete_instr = it.ci;
            complete_data  = it.cd;
            psr            = it.psr_v;
            instr_dout     = it.instr_v;
            exp_q.push_back(it);
            @(negedge clk);
            e = exp_q.pop_front();
            check("state", 16'(dut_state), 16'(e.st));
            check("enables",
                  16'({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_update_pc}),
                  16'({e.st == CNTRL_FETCH, e.st == CNTRL_DECODE, e.st == CNTRL_EXECUTE,
                       e.st == CNTRL_WRITEBACK, e.st == CNTRL_UPDATE_PC}));
            check("mem_state", 16'(mem_state), 16'(exp_mem(e.st)));
            check("branch_taken", 16'(branch_taken), 16'(e.bt));
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[17];

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{16'h1261, 3'b010, 0, 0};  // ADD
        vecs[1]  = '{16'h0405, 3'b010, 0, 0};  // BRz taken
        vecs[2]  = '{16'h0405, 3'b100, 0, 0};  // BRz not taken
        vecs[3]  = '{16'hA202, 3'b001, 0, 3};  // LDI, 3 stall cycles per memory state
        vecs[4]  = '{16'hB202, 3'b001, 0, 0};  // STI
        vecs[5]  = '{16'hD000, 3'b111, 0, 0};  // reserved -> NOP
        vecs[6]  = '{16'hC1C0, 3'b000, 0, 0};  // JMP
        vecs[7]  = '{16'h2202, 3'b010, 0, 1};  // LD
        vecs[8]  = '{16'h6202, 3'b010, 2, 0};  // LDR with fetch stall
        vecs[9]  = '{16'h3202, 3'b010, 0, 2};  // ST
        vecs[10] = '{16'h7202, 3'b010, 0, 0};  // STR
        vecs[11] = '{16'h5262, 3'b100, 0, 0};  // AND
        vecs[12] = '{16'h9A7F, 3'b001, 1, 0};  // NOT
        vecs[13] = '{16'hE202, 3'b010, 0, 0};  // LEA
        vecs[14] = '{16'hF025, 3'b111, 0, 0};  // TRAP -> NOP
        vecs[15] = '{16'h0E05, 3'b001, 0, 0};  // BRnzp taken
        vecs[16] = '{16'h0005, 3'b111, 0, 0};  // BR with no condition bits

        reset          = 1'b1;
        complete_instr = 1'b0;
        complete_data  = 1'b0;
        psr            = 3'b000;
        instr_dout     = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 16'(dut_state), 16'(CNTRL_FETCH));
        check("reset_enable_fetch", 16'(enable_fetch), 16'h1);
        check("reset_other_enables",
              16'({enable_decode, enable_execute, enable_writeback, enable_update_pc}), 16'h0);
        check("reset_mem_state", 16'(mem_state), 16'h3);
        check("reset_branch_taken", 16'(branch_taken), 16'h0);
        @(posedge clk);
        #1;

        // Table-driven instruction sequence
        for (int unsigned i = 0; i < 17; i++) begin
            build_instr(vecs[i]);
            run_queue();
        end

        // Reset while stalled in READ_MEM
        push(1'b0, 1'b1, 1'b1, 3'b000, 16'h2202, CNTRL_FETCH,    1'b0);
        push(1'b0, 1'b1, 1'b1, 3'b000, JUNK,     CNTRL_DECODE,   1'b0);
        push(1'b0, 1'b1, 1'b1, 3'b000, JUNK,     CNTRL_EXECUTE,  1'b0);
        push(1'b0, 1'b1, 1'b0, 3'b000, JUNK,     CNTRL_READ_MEM, 1'b0);
        push(1'b1, 1'b1, 1'b0, 3'b000, JUNK,     CNTRL_READ_MEM, 1'b0);
        push(1'b0, 1'b0, 1'b0, 3'b000, JUNK,     CNTRL_FETCH,    1'b0);
        run_queue();

        // Reset in JMP's EXECUTE cycle must suppress the branch decision
        push(1'b0, 1'b1, 1'b1, 3'b000, 16'hC1C0, CNTRL_FETCH,   1'b0);
        push(1'b0, 1'b1, 1'b1, 3'b000, JUNK,     CNTRL_DECODE,  1'b0);
        push(1'b1, 1'b1, 1'b1, 3'b000, JUNK,     CNTRL_EXECUTE, 1'b0);
        push(1'b0, 1'b0, 1'b1, 3'b000, JUNK,     CNTRL_FETCH,   1'b0);
        run_queue();

        // After the reset, the IR was cleared; a normal instruction still runs
        build_instr('{16'h0405, 3'b010, 0, 0});
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
